// File: rtl/instruction_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instruction_queue: serial-fill 16-bit word queue feeding the decoder     |
// | with a head word and a serial immediate shift register.   Rev 1.0        |
// +--------------------------------------------------------------------------+
module instruction_queue #(
  parameter int NSHIFT      = 2,
  parameter int QUEUE_WORDS = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               fill_valid,
  input  logic [NSHIFT-1:0]                  fill_data,
  output logic                               fill_room,
  input  logic                               flush,
  output logic                               inst_valid,
  output logic [15:0]                        inst,
  input  logic                               inst_done,
  input  logic                               load_imm16,
  output logic                               imm16_loaded,
  output logic [NSHIFT-1:0]                  imm_data_in,
  input  logic                               next_imm_data,
  output logic [$clog2(QUEUE_WORDS+1)-1:0]   queue_count
);

  localparam int BEATS = 16 / NSHIFT;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(QUEUE_WORDS + 1);

  logic [15:0]   entries_q [QUEUE_WORDS];
  logic [15:0]   entries_d [QUEUE_WORDS];
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   asm_q, asm_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          inprog_q, inprog_d;
  logic [15:0]   imm_q, imm_d;
  logic          loaded_q, loaded_d;

  logic          w_room, w_accept, w_fill_done, w_pop;
  logic [15:0]   w_asm_next;
  int            w_npop, w_base;

  always_comb begin
    w_room      = (int'(count_q) + int'(inprog_q)) < QUEUE_WORDS;
    w_accept    = fill_valid && (inprog_q || w_room);
    w_asm_next  = {fill_data, asm_q[15:NSHIFT]};
    w_fill_done = w_accept && (beat_q == BW'(BEATS - 1));
    w_pop       = inst_done && (count_q != '0);
    w_npop      = !w_pop ? 0 : (loaded_q ? 2 : 1);
    w_base      = int'(count_q) - w_npop;

    entries_d = entries_q;
    count_d   = count_q;
    asm_d     = asm_q;
    beat_d    = beat_q;
    inprog_d  = inprog_q;
    imm_d     = imm_q;
    loaded_d  = loaded_q;

    if (flush) begin
      count_d  = '0;
      asm_d    = '0;
      beat_d   = '0;
      inprog_d = 1'b0;
      imm_d    = '0;
      loaded_d = 1'b0;
    end else begin
      if (w_accept) begin
        asm_d    = w_fill_done ? '0 : w_asm_next;
        beat_d   = w_fill_done ? '0 : beat_q + BW'(1);
        inprog_d = !w_fill_done;
      end

      // Pop shifts entries down by one or two words, zero-filling the top.
      if (w_pop) begin
        for (int i = 0; i < QUEUE_WORDS; i++) begin
          entries_d[i] = '0;
          for (int j = 0; j < QUEUE_WORDS; j++) begin
            if (j == i + w_npop) entries_d[i] = entries_q[j];
          end
        end
      end

      for (int i = 0; i < QUEUE_WORDS; i++) begin
        if (w_fill_done && i == w_base) entries_d[i] = w_asm_next;
      end
      count_d = CW'(w_base + (w_fill_done ? 1 : 0));

      // A new head always reloads the imm register; this outranks load_imm16 and shifts.
      if (w_pop || (w_fill_done && count_q == '0)) begin
        imm_d    = (count_d != '0) ? {8'h00, entries_d[0][7:0]} : '0;
        loaded_d = 1'b0;
      end else if (load_imm16 && !loaded_q && int'(count_q) >= 2) begin
        imm_d    = entries_q[1];
        loaded_d = 1'b1;
      end else if (next_imm_data) begin
        imm_d = imm_q >> NSHIFT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_WORDS; i++) entries_q[i] <= '0;
      count_q  <= '0;
      asm_q    <= '0;
      beat_q   <= '0;
      inprog_q <= 1'b0;
      imm_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      for (int i = 0; i < QUEUE_WORDS; i++) entries_q[i] <= entries_d[i];
      count_q  <= count_d;
      asm_q    <= asm_d;
      beat_q   <= beat_d;
      inprog_q <= inprog_d;
      imm_q    <= imm_d;
      loaded_q <= loaded_d;
    end
  end

  assign fill_room    = w_room;
  assign inst_valid   = (count_q != '0);
  assign inst         = entries_q[0];
  assign imm16_loaded = loaded_q;
  assign imm_data_in  = imm_q[NSHIFT-1:0];
  assign queue_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_queue.sv
`default_nettype none
// Testbench for instruction_queue: directed scenarios plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_instruction_queue;

  logic        clk = 1'b0;
  logic        reset, fill_valid, flush, inst_done, load_imm16, next_imm_data;
  logic [1:0]  fill_data;
  logic        fill_room, inst_valid, imm16_loaded;
  logic [15:0] inst;
  logic [1:0]  imm_data_in;
  logic [1:0]  queue_count;

  instruction_queue #(.NSHIFT(2), .QUEUE_WORDS(3)) dut (
    .clk(clk), .reset(reset), .fill_valid(fill_valid), .fill_data(fill_data),
    .fill_room(fill_room), .flush(flush), .inst_valid(inst_valid), .inst(inst),
    .inst_done(inst_done), .load_imm16(load_imm16), .imm16_loaded(imm16_loaded),
    .imm_data_in(imm_data_in), .next_imm_data(next_imm_data), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 0;

  logic [15:0] m_q[$];
  logic [15:0] m_asm;
  int          m_beats;
  bit          m_inprog;
  logic [15:0] m_imm;
  bit          m_loaded;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("queue_count", 32'(queue_count), 32'(m_q.size()));
    chk("inst_valid", 32'(inst_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) chk("inst", 32'(inst), 32'(m_q[0]));
    chk("imm16_loaded", 32'(imm16_loaded), 32'(m_loaded));
    chk("imm_data_in", 32'(imm_data_in), 32'(m_imm[1:0]));
    chk("fill_room", 32'(fill_room), 32'((m_q.size() + int'(m_inprog)) < 3));
  endtask

  // Model of one clock edge from the current inputs and pre-edge model state.
  task automatic model_edge();
    int sz;
    bit pop, done;
    logic [15:0] w, e1;
    if (reset || flush) begin
      m_q.delete();
      m_asm = 0; m_beats = 0; m_inprog = 0; m_imm = 0; m_loaded = 0;
    end else begin
      sz   = m_q.size();
      pop  = inst_done && sz > 0;
      done = 0;
      w    = 0;
      if (fill_valid && (m_inprog || (sz + int'(m_inprog)) < 3)) begin
        m_asm = {fill_data, m_asm[15:2]};
        m_beats++;
        m_inprog = 1;
        if (m_beats == 8) begin
          done = 1; w = m_asm; m_beats = 0; m_inprog = 0;
        end
      end
      e1 = (sz >= 2) ? m_q[1] : 16'h0;
      if (pop) begin
        void'(m_q.pop_front());
        if (m_loaded) void'(m_q.pop_front());
      end
      if (done) m_q.push_back(w);
      if (pop) begin
        m_loaded = 0;
        m_imm = (m_q.size() > 0) ? {8'h00, m_q[0][7:0]} : 16'h0;
      end else if (done && sz == 0) begin
        m_imm = {8'h00, w[7:0]};
      end else if (load_imm16 && !m_loaded && sz >= 2) begin
        m_imm = e1; m_loaded = 1;
      end else if (next_imm_data) begin
        m_imm = m_imm >> 2;
      end
    end
  endtask

  // Called at a negedge: check, drive, model the edge, advance to next negedge.
  task automatic step(input bit fv, input logic [1:0] fd, input bit dn, input bit ld,
                      input bit nx, input bit fl, input bit rs);
    if (cmp_en) compare_model();
    fill_valid = fv; fill_data = fd; inst_done = dn; load_imm16 = ld;
    next_imm_data = nx; flush = fl; reset = rs;
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 2'b00, 0, 0, 0, 0, 0);
  endtask

  task automatic fill_word(input logic [15:0] w, input bit ld, input bit dn_last);
    for (int b = 0; b < 8; b++)
      step(1, w[2*b +: 2], (b == 7) ? dn_last : 1'b0, ld, 0, 0, 0);
  endtask

  task automatic pop1();
    step(0, 2'b00, 1, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; fill_valid = 0; fill_data = 0; flush = 0;
    inst_done = 0; load_imm16 = 0; next_imm_data = 0;
    @(negedge clk);
    step(0, 2'b00, 0, 0, 0, 0, 1);
    cmp_en = 1;

    chk("rst_count", 32'(queue_count), 0);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_inst", 32'(inst), 0);
    chk("rst_room", 32'(fill_room), 1);
    chk("rst_imm", 32'(imm_data_in), 0);
    chk("rst_loaded", 32'(imm16_loaded), 0);

    // Single word, then serial imm shifting of its low byte 0x23.
    fill_word(16'h8123, 0, 0);
    chk("w8123_valid", 32'(inst_valid), 1);
    chk("w8123_inst", 32'(inst), 32'h8123);
    chk("w8123_imm0", 32'(imm_data_in), 2'b11);
    step(0, 2'b00, 0, 0, 1, 0, 0);
    chk("shift1", 32'(imm_data_in), 2'b00);
    step(0, 2'b00, 0, 0, 1, 0, 0);
    chk("shift2", 32'(imm_data_in), 2'b10);
    step(0, 2'b00, 0, 0, 1, 0, 0);
    chk("shift3", 32'(imm_data_in), 2'b00);
    pop1();

    // imm16 load then double pop.
    fill_word(16'h0412, 0, 0);
    fill_word(16'hBEEF, 0, 0);
    step(0, 2'b00, 0, 1, 0, 0, 0);
    chk("ld16_loaded", 32'(imm16_loaded), 1);
    chk("ld16_imm", 32'(imm_data_in), 2'b11);
    pop1();
    chk("ld16_pop_count", 32'(queue_count), 0);
    chk("ld16_pop_valid", 32'(inst_valid), 0);

    // Full queue and pop.
    fill_word(16'h1111, 0, 0);
    fill_word(16'h2222, 0, 0);
    fill_word(16'h3333, 0, 0);
    chk("full_count", 32'(queue_count), 3);
    chk("full_room", 32'(fill_room), 0);
    pop1();
    chk("popfull_count", 32'(queue_count), 2);
    chk("popfull_inst", 32'(inst), 32'h2222);
    chk("popfull_imm", 32'(imm_data_in), 2'b10);
    chk("popfull_room", 32'(fill_room), 1);

    // Fill completion on the same edge as a pop of the only word.
    pop1();
    fill_word(16'h4444, 0, 1);
    chk("samedge_count", 32'(queue_count), 1);
    chk("samedge_inst", 32'(inst), 32'h4444);
    chk("samedge_imm", 32'(imm_data_in), 2'b00);
    pop1();

    // Flush mid-assembly.
    fill_word(16'hA5A5, 0, 0);
    fill_word(16'h5A5A, 0, 0);
    for (int b = 0; b < 4; b++) step(1, 2'b11, 0, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 1, 0);
    chk("flush_count", 32'(queue_count), 0);
    chk("flush_valid", 32'(inst_valid), 0);
    fill_word(16'h1357, 0, 0);
    chk("postflush_inst", 32'(inst), 32'h1357);
    chk("postflush_count", 32'(queue_count), 1);

    // load_imm16 held while the second word is still arriving.
    step(0, 2'b00, 0, 1, 0, 0, 0);
    chk("ld_wait0", 32'(imm16_loaded), 0);
    fill_word(16'h2468, 1, 0);
    chk("ld_wait1", 32'(imm16_loaded), 0);
    step(0, 2'b00, 0, 1, 0, 0, 0);
    chk("ld_late_loaded", 32'(imm16_loaded), 1);
    chk("ld_late_imm", 32'(imm_data_in), 2'b00);
    step(1, 2'b01, 1, 0, 0, 0, 1);
    chk("midrst_count", 32'(queue_count), 0);
    chk("midrst_loaded", 32'(imm16_loaded), 0);
    chk("midrst_room", 32'(fill_room), 1);

    // Random traffic.
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 99) < 65), 2'($urandom),
           ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 25),
           ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 999) < 5));
    end
    idle();
    compare_model();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
